// File: rtl/smem_arbiter.sv
// smem_arbiter: shares one synchronous SRAM port among NCORES cores, one load or store at a time.
// Define SMEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module smem_arbiter #(
    parameter int NCORES = 4,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCORES-1:0]    req_ld,
    input  logic [NCORES-1:0]    req_st,
    input  logic [12*NCORES-1:0] addr_flat,
    input  logic [8*NCORES-1:0]  wdata_flat,
    output logic [NCORES-1:0]    val_data,
    output logic [7:0]           rdata,
    output logic                 sram_en,
    output logic                 sram_we,
    output logic [11:0]          sram_addr,
    output logic [7:0]           sram_wdata,
    input  logic [7:0]           sram_rdata,
    output logic                 busy
);
    localparam int PW = $clog2(NCORES);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RESP, ST_ACK, ST_DATA} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     gnt_q, gnt_d;
    logic [11:0]       addr_q, addr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [NCORES-1:0] val_q, val_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              en_q, en_d;
    logic              we_q, we_d;
    logic [11:0]       saddr_q, saddr_d;
    logic [7:0]        swdata_q, swdata_d;
    logic              busy_q, busy_d;

    logic [NCORES-1:0] pend;
    logic              found;
    logic [PW-1:0]     win;

    assign pend = req_ld | req_st;

`ifdef SMEM_ARB_FIXED_PRIO_EN
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (!found && pend[k]) begin
                found = 1'b1;
                win   = PW'(k);
            end
        end
    end
`else
    logic [PW-1:0] ptr_q, ptr_d;

    // Scan upward from the core after the last winner, wrapping at NCORES-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NCORES; k++) begin
            if (!found && pend[(int'(ptr_q) + k) % NCORES]) begin
                found = 1'b1;
                win   = PW'((int'(ptr_q) + k) % NCORES);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && found)
            ptr_d = win;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= PW'(NCORES - 1);
        else       ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        val_d    = '0;
        rdata_d  = rdata_q;
        en_d     = 1'b0;
        we_d     = 1'b0;
        saddr_d  = saddr_q;
        swdata_d = swdata_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d  = win;
                    addr_d = addr_flat[12*win +: 12];
                    if (req_ld[win]) begin
                        en_d    = 1'b1;
                        saddr_d = addr_flat[12*win +: 12];
                        // One extra count covers the edge on which the SRAM samples sram_en.
                        cnt_d   = 4'(RD_LAT + 1);
                        state_d = RD_WAIT;
                    end else begin
                        val_d[win] = 1'b1;
                        state_d    = ST_ACK;
                    end
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rdata_d      = sram_rdata;
                    val_d[gnt_q] = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP:    state_d = IDLE;
            ST_ACK:  state_d = ST_DATA;
            ST_DATA: begin
                en_d     = 1'b1;
                we_d     = 1'b1;
                saddr_d  = addr_q;
                swdata_d = wdata_flat[8*gnt_q +: 8];
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            val_q    <= '0;
            rdata_q  <= '0;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            saddr_q  <= '0;
            swdata_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            val_q    <= val_d;
            rdata_q  <= rdata_d;
            en_q     <= en_d;
            we_q     <= we_d;
            saddr_q  <= saddr_d;
            swdata_q <= swdata_d;
            busy_q   <= busy_d;
        end
    end

    assign val_data   = val_q;
    assign rdata      = rdata_q;
    assign sram_en    = en_q;
    assign sram_we    = we_q;
    assign sram_addr  = saddr_q;
    assign sram_wdata = swdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_smem_arbiter.sv
// Bench for smem_arbiter: SRAM model, requester table with scoreboard, hand-timed load/store/reset sequences.
module tb_smem_arbiter;
    localparam int NC  = 4;
    localparam int RDL = 1;
    localparam int NV  = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic [NC-1:0]   req_ld, req_st;
    logic [12*NC-1:0] addr_flat;
    logic [8*NC-1:0] wdata_flat;
    logic [NC-1:0]   val_data;
    logic [7:0]      rdata;
    logic            sram_en, sram_we;
    logic [11:0]     sram_addr;
    logic [7:0]      sram_wdata;
    logic [7:0]      sram_rdata;
    logic            busy;

    always #5 clk = ~clk;

    smem_arbiter #(.NCORES(NC), .RD_LAT(RDL)) dut (
        .clk(clk), .reset(reset), .req_ld(req_ld), .req_st(req_st),
        .addr_flat(addr_flat), .wdata_flat(wdata_flat), .val_data(val_data),
        .rdata(rdata), .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
    );

    // Background SRAM contents; written locations are overlaid.
    function automatic logic [7:0] bg(logic [11:0] a);
        if (a == 12'h3A5) return 8'h5C;
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
    endfunction

    logic [7:0] wmem [4096];
    bit         wset [4096];
    logic [7:0] rd_pipe [RDL];

    always @(posedge clk) begin
        if (sram_en && sram_we) begin
            wmem[sram_addr] <= sram_wdata;
            wset[sram_addr] <= 1'b1;
        end
        rd_pipe[0] <= (sram_en && !sram_we) ? (wset[sram_addr] ? wmem[sram_addr] : bg(sram_addr)) : 8'hEE;
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_rdata = rd_pipe[RDL-1];

    typedef struct {
        int          core;
        bit          ld;
        logic [11:0] addr;
        logic [7:0]  data;
    } exp_t;

    typedef struct {
        logic [NC-1:0] ld;
        logic [NC-1:0] st;
        logic [15:0]   orr;
        logic [15:0]   ofp;
        int            n;
    } vec_t;

    exp_t exp_q[$];
    exp_t st_q[$];
    vec_t vecs[NV];
    logic [7:0] ref_mem [4096];
    int total = 0;
    int bad   = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(string nm);
        total++;
        bad++;
        $display("FAIL %s t=%0t", nm, $time);
    endtask

    function automatic logic [63:0] outs();
        return 64'({val_data, rdata, sram_en, sram_we, sram_addr, sram_wdata, busy});
    endfunction

    task automatic set_addr(int i, logic [11:0] a);
        addr_flat[12*i +: 12] = a;
    endtask

    task automatic set_wd(int i, logic [7:0] d);
        wdata_flat[8*i +: 8] = d;
    endtask

    // One clock; outputs sampled 1 time unit after the edge, scoreboard popped on each completion.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (val_data != '0) begin
            chk("val_onehot", 64'($onehot(val_data)), 64'd1);
            if (exp_q.size() == 0) fail("unexpected_val");
            else begin
                e = exp_q.pop_front();
                chk("grant_core", 64'(val_data), 64'(1 << e.core));
                if (e.ld) chk("rdata", 64'(rdata), 64'(e.data));
                else      st_q.push_back(e);
            end
            for (int i = 0; i < NC; i++)
                if (val_data[i]) begin
                    req_ld[i] = 1'b0;
                    req_st[i] = 1'b0;
                end
        end
        if (sram_en && sram_we) begin
            if (st_q.size() == 0) fail("unexpected_write");
            else begin
                e = st_q.pop_front();
                chk("wr_addr", 64'(sram_addr), 64'(e.addr));
                chk("wr_data", 64'(sram_wdata), 64'(e.data));
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        st_q.delete();
        req_ld = '0;
        req_st = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(string nm);
        int c = 0;
        while ((exp_q.size() != 0 || st_q.size() != 0 || busy) && c < 200) begin
            tick();
            c++;
        end
        if (c >= 200) begin
            fail(nm);
            exp_q.delete();
            st_q.delete();
        end
    endtask

    function automatic logic [11:0] vaddr(int vi, int c);
        return {4'(vi + 1), 4'(c), 4'h7};
    endfunction

    function automatic logic [7:0] vwd(int vi, int c);
        return {4'(vi), 4'(c)} ^ 8'h80;
    endfunction

    task automatic apply_vec(int vi);
        vec_t        v;
        logic [15:0] ord;
        logic [11:0] a;
        logic [7:0]  wd;
        int          c;
        v = vecs[vi];
`ifdef SMEM_ARB_FIXED_PRIO_EN
        ord = v.ofp;
`else
        ord = v.orr;
`endif
        for (int i = 0; i < NC; i++)
            if (v.ld[i] | v.st[i]) begin
                set_addr(i, vaddr(vi, i));
                set_wd(i, vwd(vi, i));
                req_ld[i] = v.ld[i];
                req_st[i] = v.st[i];
            end
        for (int k = 0; k < v.n; k++) begin
            c  = int'(ord[4*k +: 4]);
            a  = vaddr(vi, c);
            wd = vwd(vi, c);
            if (v.ld[c]) exp_q.push_back('{c, 1'b1, a, ref_mem[a]});
            else begin
                exp_q.push_back('{c, 1'b0, a, wd});
                ref_mem[a] = wd;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req_ld     = '0;
        req_st     = '0;
        addr_flat  = '0;
        wdata_flat = '0;
        for (int a = 0; a < 4096; a++) ref_mem[a] = bg(12'(a));

        // Orders are nibble lists, first served in the low nibble; ptr carries across vectors.
        vecs[0] = '{4'b1111, 4'b0000, 16'h3210, 16'h3210, 4};
        vecs[1] = '{4'b1001, 4'b0000, 16'h0030, 16'h0030, 2};
        vecs[2] = '{4'b0000, 4'b0110, 16'h0021, 16'h0021, 2};
        vecs[3] = '{4'b1001, 4'b0000, 16'h0003, 16'h0030, 2};
        vecs[4] = '{4'b0001, 4'b0001, 16'h0000, 16'h0000, 1};
        vecs[5] = '{4'b1010, 4'b0100, 16'h0321, 16'h0321, 3};
        vecs[6] = '{4'b0101, 4'b1010, 16'h3210, 16'h3210, 4};
        vecs[7] = '{4'b0010, 4'b0001, 16'h0010, 16'h0010, 2};
        vecs[8] = '{4'b0101, 4'b0000, 16'h0002, 16'h0020, 2};
        vecs[9] = '{4'b0010, 4'b1100, 16'h0321, 16'h0321, 3};

        tick();
        tick();
        reset = 1'b0;
        chk("reset_state", outs(), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_outs", outs(), 64'd0);
        end

        // Core 2 load of 0x3A5.
        req_ld[2] = 1'b1;
        set_addr(2, 12'h3A5);
        exp_q.push_back('{2, 1'b1, 12'h3A5, 8'h5C});
        tick();
        chk("ld_en_we", 64'({sram_en, sram_we}), 64'b10);
        chk("ld_addr", 64'(sram_addr), 64'h3A5);
        chk("ld_busy", 64'(busy), 64'd1);
        chk("ld_val_t0", 64'(val_data), 64'd0);
        tick();
        chk("ld_val_t1", 64'(val_data), 64'd0);
        chk("ld_en_once", 64'(sram_en), 64'd0);
        tick();
        chk("ld_val_t2", 64'(val_data), 64'b0100);
        chk("ld_rdata", 64'(rdata), 64'h5C);
        tick();
        chk("ld_val_t3", 64'(val_data), 64'd0);
        tick();

        // Core 1 store; write data only appears after edge t0+1.
        req_st[1] = 1'b1;
        set_addr(1, 12'h123);
        set_wd(1, 8'h00);
        exp_q.push_back('{1, 1'b0, 12'h123, 8'hA7});
        ref_mem[12'h123] = 8'hA7;
        tick();
        chk("st_ack", 64'(val_data), 64'b0010);
        chk("st_no_en_t0", 64'(sram_en), 64'd0);
        tick();
        chk("st_ack_width", 64'(val_data), 64'd0);
        chk("st_no_en_t1", 64'(sram_en), 64'd0);
        set_wd(1, 8'hA7);
        tick();
        chk("st_en_we", 64'({sram_en, sram_we}), 64'b11);
        chk("st_addr", 64'(sram_addr), 64'h123);
        chk("st_wdata", 64'(sram_wdata), 64'hA7);
        tick();
        chk("st_en_once", 64'(sram_en), 64'd0);
        drain("drain_store");

        do_reset();
        for (int v = 0; v < NV; v++) begin
            apply_vec(v);
            drain($sformatf("drain_vec%0d", v));
        end

        // Reset while core 2's read is in RD_WAIT: no completion may follow.
        req_ld[2] = 1'b1;
        set_addr(2, 12'h0F0);
        tick();
        chk("rst_ld_en", 64'(sram_en), 64'd1);
        reset  = 1'b1;
        req_ld = '0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_no_val", 64'({val_data, busy}), 64'd0);
        end
        req_ld[0] = 1'b1;
        req_ld[3] = 1'b1;
        set_addr(0, 12'hA00);
        set_addr(3, 12'hA33);
        exp_q.push_back('{0, 1'b1, 12'hA00, ref_mem[12'hA00]});
        exp_q.push_back('{3, 1'b1, 12'hA33, ref_mem[12'hA33]});
        drain("drain_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
